// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared constants, the stereo sample type and small sample-arithmetic helpers
// used by the audio sample FIFO and its storage sub-module.
//   SAMPLE_W  : width of one channel sample
//   FS_HZ     : output sample rate (pop rate of the FIFO)
//   ACC_W     : width of the phase accumulator that derives the sample tick
//   stereo_t  : packed {l, r} stereo sample
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int FS_HZ    = 48000;
    localparam int ACC_W    = 27;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } stereo_t;

    // Offset binary differs from two's complement only in the MSB.
    function automatic logic [SAMPLE_W-1:0] conv_sample(
        input logic [SAMPLE_W-1:0] s,
        input logic                offset_bin
    );
        return offset_bin ? {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]} : s;
    endfunction

    // One step of the first-order smoother y + ((x - y) >>> 2).
    // The difference needs one extra bit; the shifted difference always fits
    // back into SAMPLE_W bits, and the result lies between y and x.
    function automatic logic [SAMPLE_W-1:0] lp_step(
        input logic [SAMPLE_W-1:0] y,
        input logic [SAMPLE_W-1:0] x
    );
        logic signed [SAMPLE_W:0] diff;
        logic signed [SAMPLE_W:0] delta;
        diff  = $signed({x[SAMPLE_W-1], x}) - $signed({y[SAMPLE_W-1], y});
        delta = diff >>> 2;
        return y + SAMPLE_W'(delta);
    endfunction

endpackage

// File: rtl/audio_fifo.sv
// -----------------------------------------------------------------------------
// audio_fifo
// Synchronous stereo-sample FIFO with registered occupancy. Pointers wrap
// modulo DEPTH (power of two). The head entry is presented combinationally so
// the caller can capture it in the same cycle it pops.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset (clears pointers and level)
//   wr_en_i    : write request; ignored when full unless a read happens too
//   wr_data_i  : sample to store
//   rd_en_i    : read request; ignored when empty
//   rd_data_o  : current head entry
//   level_o    : occupancy 0..DEPTH
//   full_o     : level_o == DEPTH
//   empty_o    : level_o == 0
// -----------------------------------------------------------------------------
module audio_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  stereo_t                wr_data_i,
    input  logic                   rd_en_i,
    output stereo_t                rd_data_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    stereo_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            wr_ok, rd_ok;

    assign full_o    = (level_q == LEVEL_FULL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A write into a full FIFO is only legal when the head leaves this cycle.
    assign rd_ok = rd_en_i && !empty_o;
    assign wr_ok = wr_en_i && (!full_o || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end

    // Storage carries no reset; resetting the pointers discards its contents.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/audio_sample_fifo.sv
// -----------------------------------------------------------------------------
// audio_sample_fifo
// Rate adapter between an audio core producing stereo samples at irregular
// instants and an I2S serializer that consumes one sample per 48 kHz tick.
// A phase accumulator derives the tick from the system clock; each tick pops
// the FIFO head into the held output registers. Sticky flags report ticks on
// an empty FIFO (underflow) and samples dropped while full (overflow).
//
// Optional build macro AUDIO_LOWPASS_EN: popped samples pass through a
// first-order smoother y <= y + ((x - y) >>> 2) before reaching the outputs.
//
// Parameters: CLK_HZ (system clock Hz), DEPTH (power of two, 4..64),
//             SIGNED_IN (1 = two's complement input, 0 = offset binary)
// Ports:
//   iCLK, iRSTn            : clock, asynchronous active-low reset
//   iAUDIO_L/R, iSAMPLE_VALID : core sample and its one-cycle strobe
//   iCLR_FLAGS             : clears the sticky flags (a new error wins)
//   oREADY                 : FIFO not full
//   oAUDIO_L/R             : signed output sample, held between ticks
//   oTICK_48K              : one-cycle pulse at the pop instant
//   oLEVEL                 : FIFO occupancy 0..DEPTH
//   oUNDERFLOW, oOVERFLOW  : sticky error flags
// -----------------------------------------------------------------------------
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int CLK_HZ    = 74250000,
    parameter int DEPTH     = 8,
    parameter int SIGNED_IN = 1
) (
    input  logic                   iCLK,
    input  logic                   iRSTn,
    input  logic [SAMPLE_W-1:0]    iAUDIO_L,
    input  logic [SAMPLE_W-1:0]    iAUDIO_R,
    input  logic                   iSAMPLE_VALID,
    input  logic                   iCLR_FLAGS,
    output logic                   oREADY,
    output logic [SAMPLE_W-1:0]    oAUDIO_L,
    output logic [SAMPLE_W-1:0]    oAUDIO_R,
    output logic                   oTICK_48K,
    output logic [$clog2(DEPTH):0] oLEVEL,
    output logic                   oUNDERFLOW,
    output logic                   oOVERFLOW
);

    localparam int               LEVEL_W    = $clog2(DEPTH) + 1;
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);
    localparam logic [ACC_W:0]   CLK_LIM    = (ACC_W+1)'(CLK_HZ);
    localparam logic [ACC_W:0]   FS_INC     = (ACC_W+1)'(FS_HZ);

    // ---------------------------------------------------------------- tick
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             tick_q, tick_d;

    // One extra bit on the sum so the compare cannot wrap.
    always_comb begin
        acc_sum = {1'b0, acc_q} + FS_INC;
        tick_d  = (acc_sum >= CLK_LIM);
        acc_d   = tick_d ? ACC_W'(acc_sum - CLK_LIM) : ACC_W'(acc_sum);
    end

    // ---------------------------------------------------------------- fifo
    stereo_t              wr_sample;
    stereo_t              head;
    logic [LEVEL_W-1:0]   level;
    logic                 fifo_full, fifo_empty;
    logic                 pop, push;

    // The registered tick pulse is the pop instant.
    assign pop  = tick_q && !fifo_empty;
    assign push = iSAMPLE_VALID && (!fifo_full || pop);

    // Samples are stored already in two's complement.
    assign wr_sample.l = conv_sample(iAUDIO_L, SIGNED_IN == 0);
    assign wr_sample.r = conv_sample(iAUDIO_R, SIGNED_IN == 0);

    audio_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i     (iCLK),
        .rst_ni    (iRSTn),
        .wr_en_i   (push),
        .wr_data_i (wr_sample),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .level_o   (level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // -------------------------------------------------- output and flags
    // out_q holds the last popped sample, or the filter state when enabled;
    // in both cases it only moves on a successful pop.
    stereo_t out_q, out_d;
    logic    uf_q, uf_d;
    logic    of_q, of_d;

    always_comb begin
        out_d = out_q;
        if (pop) begin
`ifdef AUDIO_LOWPASS_EN
            out_d.l = lp_step(out_q.l, head.l);
            out_d.r = lp_step(out_q.r, head.r);
`else
            out_d = head;
`endif
        end
        // Clear first, then set, so a coinciding error is never lost.
        uf_d = (uf_q && !iCLR_FLAGS) || (tick_q && fifo_empty);
        of_d = (of_q && !iCLR_FLAGS) || (iSAMPLE_VALID && fifo_full && !pop);
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
            out_q  <= '0;
            uf_q   <= 1'b0;
            of_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
            out_q  <= out_d;
            uf_q   <= uf_d;
            of_q   <= of_d;
        end
    end

    assign oTICK_48K  = tick_q;
    assign oAUDIO_L   = out_q.l;
    assign oAUDIO_R   = out_q.r;
    assign oLEVEL     = level;
    assign oREADY     = (level != LEVEL_FULL);
    assign oUNDERFLOW = uf_q;
    assign oOVERFLOW  = of_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_fifo
// Two instances share all stimulus: dut_a takes two's complement input,
// dut_b offset binary. The reference model keeps a queue of raw samples, an
// edge counter since reset release, and derives tick instants from how many
// whole 48 kHz periods have elapsed (n * 48000 / CLK_HZ).
// -----------------------------------------------------------------------------
module tb_audio_sample_fifo;

    localparam longint CLK   = 74250000;
    localparam longint FS    = 48000;
    localparam int     DEPTH = 8;
    localparam logic [39:0] RST_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;

    logic        ready_a, tick_a, uf_a, of_a;
    logic [15:0] l_a, r_a;
    logic [3:0]  level_a;
    logic        ready_b, tick_b, uf_b, of_b;
    logic [15:0] l_b, r_b;
    logic [3:0]  level_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_sample_fifo #(.CLK_HZ(74250000), .DEPTH(DEPTH), .SIGNED_IN(1)) dut_a (
        .iCLK(clk), .iRSTn(rst_n), .iAUDIO_L(in_l), .iAUDIO_R(in_r),
        .iSAMPLE_VALID(valid), .iCLR_FLAGS(clr), .oREADY(ready_a),
        .oAUDIO_L(l_a), .oAUDIO_R(r_a), .oTICK_48K(tick_a), .oLEVEL(level_a),
        .oUNDERFLOW(uf_a), .oOVERFLOW(of_a)
    );

    audio_sample_fifo #(.CLK_HZ(74250000), .DEPTH(DEPTH), .SIGNED_IN(0)) dut_b (
        .iCLK(clk), .iRSTn(rst_n), .iAUDIO_L(in_l), .iAUDIO_R(in_r),
        .iSAMPLE_VALID(valid), .iCLR_FLAGS(clr), .oREADY(ready_b),
        .oAUDIO_L(l_b), .oAUDIO_R(r_b), .oTICK_48K(tick_b), .oLEVEL(level_b),
        .oUNDERFLOW(uf_b), .oOVERFLOW(of_b)
    );

    wire [39:0] got_a = {tick_a, ready_a, uf_a, of_a, level_a, l_a, r_a};
    wire [39:0] got_b = {tick_b, ready_b, uf_b, of_b, level_b, l_b, r_b};

    // ------------------------------------------------------------ model
    longint      m_n;
    logic [31:0] m_q[$];
    logic [15:0] m_la, m_ra, m_lb, m_rb;
    bit          m_uf, m_of;

    function automatic bit tick_at(longint n);
        if (n < 1) return 1'b0;
        return ((n * FS) / CLK) != (((n - 1) * FS) / CLK);
    endfunction

    function automatic logic [15:0] lp(logic [15:0] y, logic [15:0] x);
        int d;
        d = int'($signed(x)) - int'($signed(y));
        d = d >>> 2;
        return 16'(int'($signed(y)) + d);
    endfunction

    function automatic void model_reset();
        m_n = 0;
        m_q.delete();
        m_la = '0; m_ra = '0; m_lb = '0; m_rb = '0;
        m_uf = 1'b0; m_of = 1'b0;
    endfunction

    function automatic void model_step(bit v, logic [15:0] l, logic [15:0] r, bit c);
        bit tk, emp, ful, pop, push;
        logic [31:0] x;
        tk   = tick_at(m_n);
        emp  = (m_q.size() == 0);
        ful  = (m_q.size() == DEPTH);
        pop  = tk && !emp;
        push = v && (!ful || pop);
        if (pop) begin
            x = m_q.pop_front();
`ifdef AUDIO_LOWPASS_EN
            m_la = lp(m_la, x[31:16]);
            m_ra = lp(m_ra, x[15:0]);
            m_lb = lp(m_lb, x[31:16] ^ 16'h8000);
            m_rb = lp(m_rb, x[15:0] ^ 16'h8000);
`else
            m_la = x[31:16];
            m_ra = x[15:0];
            m_lb = x[31:16] ^ 16'h8000;
            m_rb = x[15:0] ^ 16'h8000;
`endif
        end
        if (push) m_q.push_back({l, r});
        m_uf = (m_uf && !c) || (tk && emp);
        m_of = (m_of && !c) || (v && ful && !pop);
        m_n++;
    endfunction

    function automatic logic [39:0] exp_vec(bit b);
        logic [15:0] el, er;
        el = b ? m_lb : m_la;
        er = b ? m_rb : m_ra;
        return {tick_at(m_n), (m_q.size() != DEPTH), m_uf, m_of, 4'(m_q.size()), el, er};
    endfunction

    // ------------------------------------------------------- stimulus
    task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r, input bit c);
        valid = v; in_l = l; in_r = r; clr = c;
        @(posedge clk);
        model_step(v, l, r, c);
        @(negedge clk);
        valid = 1'b0; clr = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; valid = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0);
            if (tick_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; in_l = 16'h5555; in_r = 16'hAAAA;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (got_a !== RST_VEC) begin
            n_fail++; $display("FAIL reset_a: got %h expected %h", got_a, RST_VEC);
        end
        n_checks++;
        if (got_b !== RST_VEC) begin
            n_fail++; $display("FAIL reset_b: got %h expected %h", got_b, RST_VEC);
        end
        valid = 1'b0;
        $display("reset: outputs checked while held in reset");
    endtask

    task automatic test_first_tick();
        longint first;
        apply_reset();
        first = 0;
        for (int i = 0; i < 2000 && first == 0; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0);
            n_checks++;
            if (got_a !== exp_vec(0)) begin
                n_fail++; $display("FAIL idle_cycle %0d: got %h expected %h", m_n, got_a, exp_vec(0));
            end
            if (tick_a === 1'b1) first = m_n;
        end
        n_checks++;
        if (first != 1547) begin
            n_fail++; $display("FAIL first_tick_edge: got %0d expected 1547", first);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0);
        n_checks++;
        if ({uf_a, l_a, r_a, uf_b, l_b, r_b} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL first_underflow: got %h expected %h",
                {uf_a, l_a, r_a, uf_b, l_b, r_b}, {1'b1, 32'h0, 1'b1, 32'h0});
        end
        $display("first_tick: tick at edge %0d, underflow=%0b", first, uf_a);
    endtask

    task automatic test_single_push();
        bit ok;
        logic [31:0] exp;
        apply_reset();
        repeat (9) step(1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b1, 16'h1234, 16'hABCD, 1'b0);
        n_checks++;
        if (level_a !== 4'd1) begin
            n_fail++; $display("FAIL push_level: got %0d expected 1", level_a);
        end
        wait_tick(ok);
        n_checks++;
        if (!ok || {level_a, l_a, r_a} !== {4'd1, 32'h0}) begin
            n_fail++; $display("FAIL tick_cycle_hold: got %h expected %h (tick seen %0b)",
                {level_a, l_a, r_a}, {4'd1, 32'h0}, ok);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0);
`ifdef AUDIO_LOWPASS_EN
        exp = {lp(16'h0, 16'h1234), lp(16'h0, 16'hABCD)};
`else
        exp = {16'h1234, 16'hABCD};
`endif
        n_checks++;
        if ({level_a, l_a, r_a} !== {4'd0, exp}) begin
            n_fail++; $display("FAIL single_pop: got %h expected %h", {level_a, l_a, r_a}, {4'd0, exp});
        end
        n_checks++;
        if (got_b !== exp_vec(1)) begin
            n_fail++; $display("FAIL single_pop_b: got %h expected %h", got_b, exp_vec(1));
        end
        $display("single_push: out=%h_%h level=%0d", l_a, r_a, level_a);
    endtask

    task automatic test_offset_binary();
        bit ok;
        logic [31:0] exp_a, exp_b;
        apply_reset();
        step(1'b1, 16'h8000, 16'h0000, 1'b0);
        wait_tick(ok);
        step(1'b0, 16'h0, 16'h0, 1'b0);
`ifdef AUDIO_LOWPASS_EN
        exp_a = {lp(16'h0, 16'h8000), lp(16'h0, 16'h0000)};
        exp_b = {lp(16'h0, 16'h0000), lp(16'h0, 16'h8000)};
`else
        exp_a = {16'h8000, 16'h0000};
        exp_b = {16'h0000, 16'h8000};
`endif
        n_checks++;
        if (!ok || {l_b, r_b} !== exp_b) begin
            n_fail++; $display("FAIL offset_binary_b: got %h expected %h", {l_b, r_b}, exp_b);
        end
        n_checks++;
        if ({l_a, r_a} !== exp_a) begin
            n_fail++; $display("FAIL offset_binary_a: got %h expected %h", {l_a, r_a}, exp_a);
        end
        $display("offset_binary: b out=%h_%h a out=%h_%h", l_b, r_b, l_a, r_a);
    endtask

    task automatic test_overflow();
        bit ok;
        logic [15:0] yl, yr;
        apply_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
        n_checks++;
        if ({level_a, ready_a, of_a, uf_a} !== {4'd8, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL overflow_state: got %h expected %h",
                {level_a, ready_a, of_a, uf_a}, {4'd8, 1'b0, 1'b1, 1'b0});
        end
        yl = '0; yr = '0;
        for (int k = 0; k < 9; k++) begin
            wait_tick(ok);
            step(1'b0, 16'h0, 16'h0, 1'b0);
`ifdef AUDIO_LOWPASS_EN
            if (k < 8) begin yl = lp(yl, 16'h1000 + 16'(k)); yr = lp(yr, 16'h2000 + 16'(k)); end
`else
            if (k < 8) begin yl = 16'h1000 + 16'(k); yr = 16'h2000 + 16'(k); end
`endif
            n_checks++;
            if (!ok || {l_a, r_a, uf_a} !== {yl, yr, (k == 8)}) begin
                n_fail++; $display("FAIL overflow_pop %0d: got %h expected %h", k, {l_a, r_a, uf_a}, {yl, yr, (k == 8)});
            end
            $display("overflow pop %0d: out=%h_%h level=%0d uf=%0b", k, l_a, r_a, level_a, uf_a);
        end
    endtask

    task automatic test_full_push_tick();
        bit ok;
        logic [31:0] exp;
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h3000 + 16'(i), 16'h4000 + 16'(i), 1'b0);
        wait_tick(ok);
        step(1'b1, 16'h5555, 16'h6666, 1'b0);
`ifdef AUDIO_LOWPASS_EN
        exp = {lp(16'h0, 16'h3000), lp(16'h0, 16'h4000)};
`else
        exp = {16'h3000, 16'h4000};
`endif
        n_checks++;
        if (!ok || {level_a, ready_a, of_a, l_a, r_a} !== {4'd8, 1'b0, 1'b0, exp}) begin
            n_fail++; $display("FAIL full_push_pop: got %h expected %h",
                {level_a, ready_a, of_a, l_a, r_a}, {4'd8, 1'b0, 1'b0, exp});
        end
        step(1'b1, 16'h7777, 16'h8888, 1'b0);
        n_checks++;
        if ({of_a, level_a} !== {1'b1, 4'd8}) begin
            n_fail++; $display("FAIL full_drop: got %h expected %h", {of_a, level_a}, {1'b1, 4'd8});
        end
        step(1'b0, 16'h0, 16'h0, 1'b1);
        n_checks++;
        if ({uf_a, of_a, uf_b, of_b} !== 4'b0000) begin
            n_fail++; $display("FAIL clear_flags: got %b expected 0000", {uf_a, of_a, uf_b, of_b});
        end
        step(1'b1, 16'h9999, 16'hAAAA, 1'b1);
        n_checks++;
        if ({of_a, of_b} !== 2'b11) begin
            n_fail++; $display("FAIL set_wins: got %b expected 11", {of_a, of_b});
        end
        n_checks++;
        if (got_b !== exp_vec(1)) begin
            n_fail++; $display("FAIL full_model_b: got %h expected %h", got_b, exp_vec(1));
        end
        $display("full_push_tick: level=%0d of=%0b out=%h_%h", level_a, of_a, l_a, r_a);
    endtask

    task automatic test_filter_step();
        bit ok;
        logic [15:0] exp_step [3];
`ifdef AUDIO_LOWPASS_EN
        exp_step[0] = 16'h1000; exp_step[1] = 16'h1C00; exp_step[2] = 16'h2500;
`else
        exp_step[0] = 16'h4000; exp_step[1] = 16'h4000; exp_step[2] = 16'h4000;
`endif
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'h4000, 16'h4000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_tick(ok);
            step(1'b0, 16'h0, 16'h0, 1'b0);
            n_checks++;
            if (!ok || {l_a, r_a} !== {exp_step[k], exp_step[k]}) begin
                n_fail++; $display("FAIL step_response %0d: got %h expected %h", k, {l_a, r_a}, {exp_step[k], exp_step[k]});
            end
            $display("step_response %0d: out=%h", k, l_a);
        end
    endtask

    task automatic test_random();
        bit v, c;
        logic [15:0] l, r;
        apply_reset();
        for (int cyc = 0; cyc < 30000; cyc++) begin
            if (cyc == 6000) begin
                #2 rst_n = 1'b0;
                #1;
                n_checks++;
                if (got_a !== RST_VEC || got_b !== RST_VEC) begin
                    n_fail++; $display("FAIL midrun_reset: got %h/%h expected %h", got_a, got_b, RST_VEC);
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            v = (cyc < 12000) ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 5999) == 0);
            c = ($urandom_range(0, 1999) == 0);
            l = 16'($urandom);
            r = 16'($urandom);
            step(v, l, r, c);
            n_checks++;
            if (got_a !== exp_vec(0)) begin
                n_fail++; $display("FAIL random_a cyc %0d: got %h expected %h", cyc, got_a, exp_vec(0));
            end
            n_checks++;
            if (got_b !== exp_vec(1)) begin
                n_fail++; $display("FAIL random_b cyc %0d: got %h expected %h", cyc, got_b, exp_vec(1));
            end
        end
        $display("random: final level=%0d uf=%0b of=%0b", level_a, uf_a, of_a);
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_single_push();
        test_offset_binary();
        test_overflow();
        test_full_push_tick();
        test_filter_step();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
